sync_fifo_param: RTL and testbench

Parametrised single-clock FIFO and the successor to the fixed 8-bit sync_fifo. Adds configurable width and depth, almost-full and almost-empty thresholds, an occupancy count, and overflow/underflow error pulses. Also adds a selectable output mode: registered read or first-word-fall-through (FWFT). Used as the general buffering block between same-clock producer/consumer stages.

---
 rtl/sync_fifo_pkg.sv | 18 +
 rtl/fifo_dpram.sv | 26 ++
 rtl/sync_fifo_param.sv | 158 +++++++++++++++
 tb/tb_sync_fifo_param.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared constants and helpers for the parametrised synchronous FIFO.
package sync_fifo_pkg;

    // Output mode selectors for the FWFT parameter
    localparam int unsigned FWFT_OFF = 0;
    localparam int unsigned FWFT_ON  = 1;

    // Ceiling log2, usable in constant expressions
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((64'(1) << r) < 64'(value)) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_dpram.sv
// Simple dual-port storage array: synchronous write, asynchronous read.
module fifo_dpram #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Write port; contents intentionally carry no reset
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy flags, error pulses and
// selectable registered or first-word-fall-through read output.
module sync_fifo_param
    import sync_fifo_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned AF_THRESH = DEPTH - 2,
    parameter int unsigned AE_THRESH = 2,
    parameter int unsigned FWFT      = FWFT_OFF
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [DATA_W-1:0]           data_in,
    input  logic                        en_wr,
    input  logic                        en_rd,
    output logic [DATA_W-1:0]           data_out,
    output logic                        rd_valid,
    output logic                        empty,
    output logic                        full,
    output logic                        almost_empty,
    output logic                        almost_full,
    output logic [clog2(DEPTH):0]       count,
    output logic                        overflow,
    output logic                        underflow
);

    localparam int unsigned ADDR_W = clog2(DEPTH);
    localparam int unsigned PTR_W  = ADDR_W + 1;
    localparam int unsigned CNT_W  = ADDR_W + 1;

    // Parameter sanity checks
    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("sync_fifo_param: DEPTH must be a power of 2 and >= 4");
    end
    if (AF_THRESH > DEPTH) begin : g_bad_af
        $error("sync_fifo_param: AF_THRESH must not exceed DEPTH");
    end
    if (AE_THRESH >= DEPTH) begin : g_bad_ae
        $error("sync_fifo_param: AE_THRESH must be below DEPTH");
    end

    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_empty;
    logic              r_full;
    logic              r_almost_empty;
    logic              r_almost_full;
    logic              r_overflow;
    logic              r_underflow;

    logic              w_wr_acc;
    logic              w_rd_acc;
    logic [PTR_W-1:0]  w_wr_ptr_nxt;
    logic [PTR_W-1:0]  w_rd_ptr_nxt;
    logic [CNT_W-1:0]  w_count_nxt;
    logic              w_empty_nxt;
    logic              w_full_nxt;
    logic [DATA_W-1:0] w_rd_data;

    // Acceptance is decided from the flags held at the start of the cycle
    assign w_wr_acc = en_wr && !r_full;
    assign w_rd_acc = en_rd && !r_empty;

    // Next pointer, occupancy and flag values
    always_comb begin
        w_wr_ptr_nxt = r_wr_ptr;
        w_rd_ptr_nxt = r_rd_ptr;
        w_count_nxt  = r_count;
        if (w_wr_acc) begin
            w_wr_ptr_nxt = r_wr_ptr + PTR_W'(1);
        end
        if (w_rd_acc) begin
            w_rd_ptr_nxt = r_rd_ptr + PTR_W'(1);
        end
        case ({w_wr_acc, w_rd_acc})
            2'b10:   w_count_nxt = r_count + CNT_W'(1);
            2'b01:   w_count_nxt = r_count - CNT_W'(1);
            default: w_count_nxt = r_count;
        endcase
        w_empty_nxt = (w_wr_ptr_nxt == w_rd_ptr_nxt);
        w_full_nxt  = (w_wr_ptr_nxt[ADDR_W] != w_rd_ptr_nxt[ADDR_W]) &&
                      (w_wr_ptr_nxt[ADDR_W-1:0] == w_rd_ptr_nxt[ADDR_W-1:0]);
    end

    // Pointer, count, flag and error-pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_empty        <= 1'b1;
            r_full         <= 1'b0;
            r_almost_empty <= 1'b1;
            r_almost_full  <= 1'b0;
            r_overflow     <= 1'b0;
            r_underflow    <= 1'b0;
        end else begin
            r_wr_ptr       <= w_wr_ptr_nxt;
            r_rd_ptr       <= w_rd_ptr_nxt;
            r_count        <= w_count_nxt;
            r_empty        <= w_empty_nxt;
            r_full         <= w_full_nxt;
            r_almost_empty <= (w_count_nxt <= CNT_W'(AE_THRESH));
            r_almost_full  <= (w_count_nxt >= CNT_W'(AF_THRESH));
            r_overflow     <= en_wr && r_full;
            r_underflow    <= en_rd && r_empty;
        end
    end

    fifo_dpram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_wr_acc),
        .i_waddr (r_wr_ptr[ADDR_W-1:0]),
        .i_wdata (data_in),
        .i_raddr (r_rd_ptr[ADDR_W-1:0]),
        .o_rdata (w_rd_data)
    );

    if (FWFT == FWFT_OFF) begin : g_reg_read
        logic [DATA_W-1:0] r_data_out;
        logic              r_rd_valid;

        // Registered read: capture the head word when a pop is accepted
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_data_out <= '0;
                r_rd_valid <= 1'b0;
            end else begin
                r_rd_valid <= w_rd_acc;
                if (w_rd_acc) begin
                    r_data_out <= w_rd_data;
                end
            end
        end

        assign data_out = r_data_out;
        assign rd_valid = r_rd_valid;
    end else begin : g_fwft_read
        // Head word is presented directly; forced to zero while empty
        assign data_out = r_empty ? '0 : w_rd_data;
        assign rd_valid = !r_empty;
    end

    assign empty        = r_empty;
    assign full         = r_full;
    assign almost_empty = r_almost_empty;
    assign almost_full  = r_almost_full;
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: one registered-read and one FWFT instance share
// stimulus; a queue model is checked every cycle plus directed literal checks.
module tb_sync_fifo_param;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned AF    = DEPTH - 2;
    localparam int unsigned AE    = 2;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] data_in;
    logic          en_wr;
    logic          en_rd;

    logic [DW-1:0] d0_dout, d1_dout;
    logic          d0_rv, d1_rv, d0_empty, d1_empty, d0_full, d1_full;
    logic          d0_ae, d1_ae, d0_af, d1_af, d0_ovf, d1_ovf, d0_udf, d1_udf;
    logic [4:0]    d0_cnt, d1_cnt;

    int errors = 0;
    int checks = 0;

    // Behavioural model state
    logic [DW-1:0] mq[$];
    logic [DW-1:0] m_dout;
    logic          m_rv, m_ovf, m_udf;

    sync_fifo_param #(.DATA_W(DW), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .en_wr(en_wr), .en_rd(en_rd),
        .data_out(d0_dout), .rd_valid(d0_rv), .empty(d0_empty), .full(d0_full),
        .almost_empty(d0_ae), .almost_full(d0_af), .count(d0_cnt),
        .overflow(d0_ovf), .underflow(d0_udf)
    );

    sync_fifo_param #(.DATA_W(DW), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .en_wr(en_wr), .en_rd(en_rd),
        .data_out(d1_dout), .rd_valid(d1_rv), .empty(d1_empty), .full(d1_full),
        .almost_empty(d1_ae), .almost_full(d1_af), .count(d1_cnt),
        .overflow(d1_ovf), .underflow(d1_udf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_dout = '0;
        m_rv   = 1'b0;
        m_ovf  = 1'b0;
        m_udf  = 1'b0;
    endtask

    // One clock of stimulus; the model advances using start-of-cycle occupancy
    task automatic step(input logic wr, input logic [DW-1:0] din, input logic rd);
        int  n;
        bit  wa, ra;
        en_wr   = wr;
        data_in = din;
        en_rd   = rd;
        @(posedge clk);
        n     = mq.size();
        wa    = wr && (n != DEPTH);
        ra    = rd && (n != 0);
        m_ovf = wr && (n == DEPTH);
        m_udf = rd && (n == 0);
        m_rv  = ra;
        if (ra) m_dout = mq.pop_front();
        if (wa) mq.push_back(din);
        @(negedge clk);
        en_wr = 1'b0;
        en_rd = 1'b0;
    endtask

    // Per-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (rst_n) begin
            int n;
            n = mq.size();
            chk("count0", 32'(d0_cnt), 32'(n));
            chk("count1", 32'(d1_cnt), 32'(n));
            chk("empty0", 32'(d0_empty), 32'(n == 0));
            chk("empty1", 32'(d1_empty), 32'(n == 0));
            chk("full0", 32'(d0_full), 32'(n == DEPTH));
            chk("full1", 32'(d1_full), 32'(n == DEPTH));
            chk("ae0", 32'(d0_ae), 32'(n <= AE));
            chk("af0", 32'(d0_af), 32'(n >= AF));
            chk("ae1", 32'(d1_ae), 32'(n <= AE));
            chk("af1", 32'(d1_af), 32'(n >= AF));
            chk("ovf0", 32'(d0_ovf), 32'(m_ovf));
            chk("udf0", 32'(d0_udf), 32'(m_udf));
            chk("ovf1", 32'(d1_ovf), 32'(m_ovf));
            chk("udf1", 32'(d1_udf), 32'(m_udf));
            chk("dout0", 32'(d0_dout), 32'(m_dout));
            chk("rv0", 32'(d0_rv), 32'(m_rv));
            chk("rv1", 32'(d1_rv), 32'(n != 0));
            if (n != 0) chk("dout1", 32'(d1_dout), 32'(mq[0]));
        end
    end

    initial begin
        logic [DW-1:0] fill[8];
        rst_n   = 1'b0;
        en_wr   = 1'b0;
        en_rd   = 1'b0;
        data_in = '0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_empty", 32'(d0_empty), 32'd1);
        chk("rst_ae", 32'(d0_ae), 32'd1);
        chk("rst_cnt", 32'(d0_cnt), 32'd0);
        chk("rst_dout", 32'(d0_dout), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1. Fill
        for (int i = 0; i < 16; i++) begin
            step(1'b1, DW'(i + 1), 1'b0);
            if (i == 12) chk("af_at13", 32'(d0_af), 32'd0);
            if (i == 13) chk("af_at14", 32'(d0_af), 32'd1);
        end
        chk("fill_full", 32'(d0_full), 32'd1);
        chk("fill_cnt", 32'(d0_cnt), 32'd16);
        step(1'b1, 8'hEE, 1'b0);
        chk("ovf_pulse", 32'(d0_ovf), 32'd1);
        chk("ovf_cnt", 32'(d0_cnt), 32'd16);
        step(1'b0, 8'h00, 1'b0);
        chk("ovf_clear", 32'(d0_ovf), 32'd0);

        // 2. Drain
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 8'h00, 1'b1);
            chk("drain_data", 32'(d0_dout), 32'(i + 1));
            chk("drain_rv", 32'(d0_rv), 32'd1);
        end
        chk("drain_empty", 32'(d0_empty), 32'd1);
        step(1'b0, 8'h00, 1'b1);
        chk("udf_pulse", 32'(d0_udf), 32'd1);
        chk("udf_hold", 32'(d0_dout), 32'h10);
        chk("udf_rv", 32'(d0_rv), 32'd0);

        // 3. Steady state across pointer wrap
        for (int i = 0; i < 8; i++) begin
            fill[i] = DW'(8'h40 + i);
            step(1'b1, fill[i], 1'b0);
        end
        for (int i = 0; i < 20; i++) begin
            step(1'b1, DW'(8'h20 + i), 1'b1);
            chk("ss_cnt", 32'(d0_cnt), 32'd8);
            chk("ss_data", 32'(d0_dout), (i < 8) ? 32'(fill[i]) : 32'(8'h20 + i - 8));
        end
        for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1);
        chk("ss_last", 32'(d0_dout), 32'h33);

        // 4. Boundaries
        step(1'b1, 8'h55, 1'b1);
        chk("bnd_e_cnt", 32'(d0_cnt), 32'd1);
        chk("bnd_e_udf", 32'(d0_udf), 32'd1);
        for (int i = 0; i < 15; i++) step(1'b1, DW'(8'h60 + i), 1'b0);
        step(1'b1, 8'hCC, 1'b1);
        chk("bnd_f_cnt", 32'(d0_cnt), 32'd15);
        chk("bnd_f_ovf", 32'(d0_ovf), 32'd1);
        chk("bnd_f_data", 32'(d0_dout), 32'h55);
        for (int i = 0; i < 15; i++) step(1'b0, 8'h00, 1'b1);

        // 5. FWFT
        step(1'b1, 8'hA5, 1'b0);
        chk("fwft_empty", 32'(d1_empty), 32'd0);
        chk("fwft_data", 32'(d1_dout), 32'hA5);
        chk("fwft_rv", 32'(d1_rv), 32'd1);
        step(1'b0, 8'h00, 1'b1);
        chk("fwft_pop", 32'(d1_empty), 32'd1);
        chk("fwft_reg", 32'(d0_dout), 32'hA5);

        // 6. Asynchronous reset mid-stream
        for (int i = 0; i < 5; i++) step(1'b1, DW'(8'h90 + i), 1'b0);
        chk("pre_rst_cnt", 32'(d0_cnt), 32'd5);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("arst_cnt", 32'(d0_cnt), 32'd0);
        chk("arst_empty", 32'(d0_empty), 32'd1);
        chk("arst_full", 32'(d0_full), 32'd0);
        chk("arst_ae", 32'(d0_ae), 32'd1);
        chk("arst_af", 32'(d0_af), 32'd0);
        chk("arst_dout", 32'(d0_dout), 32'd0);
        chk("arst_rv", 32'(d0_rv), 32'd0);
        chk("arst_empty1", 32'(d1_empty), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 8'h77, 1'b0);
        chk("post_fwft", 32'(d1_dout), 32'h77);
        step(1'b0, 8'h00, 1'b1);
        chk("post_data", 32'(d0_dout), 32'h77);
        chk("post_empty", 32'(d0_empty), 32'd1);
        step(1'b0, 8'h00, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
